// File: rtl/slot_select_ctrl_pkg.sv
// Shared types and constants for the vending slot-selection controller.
package slot_select_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BROWSE = 2'd1,
        ST_HOLD   = 2'd2,
        ST_VEND   = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_SLOT = 0;

    // Index width for n items, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/slot_select_ctrl_rise_detect.sv
// Registered rising-edge detector; rise_c is high in the cycle d first reads 1.
module slot_select_ctrl_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise_c
);

    logic d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise_c = d & ~d_q;

endmodule

// File: rtl/slot_select_ctrl.sv
// Slot inquiry and purchase-selection controller: browses slots, reports stock,
// and holds a purchase request to payment until done, abort, cancel or timeout.
module slot_select_ctrl
    import slot_select_ctrl_pkg::*;
#(
    parameter  int unsigned N_SLOTS     = 8,
    parameter  int unsigned STOCK_W     = 4,
    parameter  int unsigned TIMEOUT_CYC = 1000,
    localparam int unsigned SLOT_W      = clog2_min1(N_SLOTS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       browse_en,
    input  logic [SLOT_W-1:0]          slot_in,
    input  logic                       confirm,
    input  logic                       cancel,
    input  logic [N_SLOTS*STOCK_W-1:0] stock_in,
    input  logic                       pay_done,
    input  logic                       pay_abort,
    output logic [SLOT_W-1:0]          view_slot,
    output logic [STOCK_W-1:0]         view_stock,
    output logic                       sold_out,
    output logic [SLOT_W-1:0]          buy_slot,
    output logic                       buy_req,
    output logic                       vend_pulse,
    output logic                       err_pulse,
    output logic                       timeout
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_t              state;
    state_t              state_nxt;
    logic [SLOT_W-1:0]   view_slot_nxt;
    logic [SLOT_W-1:0]   buy_slot_nxt;
    logic                buy_req_nxt;
    logic                vend_pulse_nxt;
    logic                err_pulse_nxt;
    logic                timeout_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                confirm_rise;
    logic                slot_ok;

    slot_select_ctrl_rise_detect u_confirm_rise (
        .clk    (clk),
        .rst    (rst),
        .d      (confirm),
        .rise_c (confirm_rise)
    );

    // Stock of the browsed slot, valid in every state.
    always_comb begin
        view_stock = '0;
        for (int k = 0; k < int'(N_SLOTS); k++) begin
            if (view_slot == SLOT_W'(k)) begin
                view_stock = stock_in[k*STOCK_W +: STOCK_W];
            end
        end
    end

    assign sold_out = (view_stock == '0);
    assign slot_ok  = (32'(slot_in) < N_SLOTS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            view_slot  <= SLOT_W'(DEFAULT_SLOT);
            buy_slot   <= SLOT_W'(DEFAULT_SLOT);
            buy_req    <= 1'b0;
            vend_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            timeout    <= 1'b0;
            cnt        <= '0;
        end else begin
            state      <= state_nxt;
            view_slot  <= view_slot_nxt;
            buy_slot   <= buy_slot_nxt;
            buy_req    <= buy_req_nxt;
            vend_pulse <= vend_pulse_nxt;
            err_pulse  <= err_pulse_nxt;
            timeout    <= timeout_nxt;
            cnt        <= cnt_nxt;
        end
    end

    // Next state and next values of all registered outputs.
    always_comb begin
        state_nxt      = state;
        view_slot_nxt  = view_slot;
        buy_slot_nxt   = buy_slot;
        buy_req_nxt    = 1'b0;
        vend_pulse_nxt = 1'b0;
        err_pulse_nxt  = 1'b0;
        timeout_nxt    = 1'b0;
        cnt_nxt        = '0;

        case (state)
            ST_IDLE: begin
                if (browse_en) begin
                    state_nxt = ST_BROWSE;
                end
            end

            ST_BROWSE: begin
                if (slot_ok) begin
                    view_slot_nxt = slot_in;
                end
                // Leaving browse wins over a confirm in the same cycle.
                if (!browse_en) begin
                    state_nxt = ST_IDLE;
                end else if (confirm_rise) begin
                    if (sold_out) begin
                        err_pulse_nxt = 1'b1;
                    end else begin
                        state_nxt    = ST_HOLD;
                        buy_slot_nxt = view_slot;
                        buy_req_nxt  = 1'b1;
                    end
                end
            end

            ST_HOLD: begin
                buy_req_nxt = 1'b1;
                cnt_nxt     = cnt + CNT_W'(1);
                if (pay_done) begin
                    state_nxt      = ST_VEND;
                    buy_req_nxt    = 1'b0;
                    vend_pulse_nxt = 1'b1;
                    cnt_nxt        = '0;
                end else if (pay_abort || cancel) begin
                    state_nxt   = ST_IDLE;
                    buy_req_nxt = 1'b0;
                    cnt_nxt     = '0;
                end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_nxt   = ST_IDLE;
                    buy_req_nxt = 1'b0;
                    timeout_nxt = 1'b1;
                    cnt_nxt     = '0;
                end
            end

            ST_VEND: begin
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_slot_select_ctrl.sv
// Bench for slot_select_ctrl: directed scenarios followed by random traffic,
// each cycle compared against a behavioural purchase model.
module tb_slot_select_ctrl;

    localparam int unsigned N  = 6;
    localparam int unsigned SW = 4;
    localparam int unsigned TO = 16;
    localparam int unsigned LW = 3;

    logic            clk;
    logic            rst;
    logic            browse_en;
    logic [LW-1:0]   slot_in;
    logic            confirm;
    logic            cancel;
    logic [N*SW-1:0] stock_in;
    logic            pay_done;
    logic            pay_abort;
    logic [LW-1:0]   view_slot;
    logic [SW-1:0]   view_stock;
    logic            sold_out;
    logic [LW-1:0]   buy_slot;
    logic            buy_req;
    logic            vend_pulse;
    logic            err_pulse;
    logic            timeout;

    int n_cmp;
    int n_err;

    // Model state: phase 0 idle, 1 browsing, 2 purchase held, 3 dispensing.
    int            m_phase;
    int            m_age;
    logic [LW-1:0] m_view;
    logic [LW-1:0] m_buy;
    logic          m_prev;
    logic          m_vend;
    logic          m_err;
    logic          m_to;

    slot_select_ctrl #(
        .N_SLOTS     (N),
        .STOCK_W     (SW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .browse_en  (browse_en),
        .slot_in    (slot_in),
        .confirm    (confirm),
        .cancel     (cancel),
        .stock_in   (stock_in),
        .pay_done   (pay_done),
        .pay_abort  (pay_abort),
        .view_slot  (view_slot),
        .view_stock (view_stock),
        .sold_out   (sold_out),
        .buy_slot   (buy_slot),
        .buy_req    (buy_req),
        .vend_pulse (vend_pulse),
        .err_pulse  (err_pulse),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [SW-1:0] stock_of(input int k);
        return stock_in[k*SW +: SW];
    endfunction

    task automatic set_stock(input int k, input logic [SW-1:0] v);
        stock_in[k*SW +: SW] = v;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_age   = 0;
        m_view  = '0;
        m_buy   = '0;
        m_prev  = 1'b0;
        m_vend  = 1'b0;
        m_err   = 1'b0;
        m_to    = 1'b0;
    endtask

    // One clock of the purchase rules, using the inputs present at the edge.
    task automatic model_step();
        logic          rose;
        logic [SW-1:0] s;
        rose   = confirm && !m_prev;
        m_prev = confirm;
        s      = stock_of(int'(m_view));
        m_vend = 1'b0;
        m_err  = 1'b0;
        m_to   = 1'b0;
        case (m_phase)
            0: if (browse_en) m_phase = 1;
            1: begin
                if (!browse_en) begin
                    m_phase = 0;
                end else if (rose) begin
                    if (s != 0) begin
                        m_phase = 2;
                        m_buy   = m_view;
                        m_age   = 0;
                    end else begin
                        m_err = 1'b1;
                    end
                end
                if (int'(slot_in) < int'(N)) m_view = slot_in;
            end
            2: begin
                m_age++;
                if (pay_done) begin
                    m_phase = 3;
                    m_vend  = 1'b1;
                end else if (pay_abort || cancel) begin
                    m_phase = 0;
                end else if (m_age == int'(TO)) begin
                    m_phase = 0;
                    m_to    = 1'b1;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic compare_all();
        check("view_slot", 32'(view_slot), 32'(m_view));
        check("view_stock", 32'(view_stock), 32'(stock_of(int'(m_view))));
        check("sold_out", 32'(sold_out), 32'(stock_of(int'(m_view)) == 0));
        check("buy_req", 32'(buy_req), 32'(m_phase == 2));
        check("buy_slot", 32'(buy_slot), 32'(m_buy));
        check("vend_pulse", 32'(vend_pulse), 32'(m_vend));
        check("err_pulse", 32'(err_pulse), 32'(m_err));
        check("timeout", 32'(timeout), 32'(m_to));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int hold_cycles;
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        browse_en = 1'b0;
        slot_in   = '0;
        confirm   = 1'b0;
        cancel    = 1'b0;
        pay_done  = 1'b0;
        pay_abort = 1'b0;
        stock_in  = '0;
        model_reset();
        ticks(2);
        check("rst_view_slot", 32'(view_slot), 32'd0);
        check("rst_buy_req", 32'(buy_req), 32'd0);
        check("rst_pulses", {29'd0, vend_pulse, err_pulse, timeout}, 32'd0);
        rst = 1'b0;

        // Browse to slot 5 and report its stock.
        browse_en = 1'b1;
        slot_in   = 3'd5;
        set_stock(5, 4'd3);
        ticks(2);
        check("t1_view_slot", 32'(view_slot), 32'd5);
        check("t1_view_stock", 32'(view_stock), 32'd3);
        check("t1_sold_out", 32'(sold_out), 32'd0);

        // Out-of-range slot number leaves the view unchanged.
        slot_in = 3'd7;
        ticks(2);
        check("t2_view_hold", 32'(view_slot), 32'd5);
        check("t2_no_err", 32'(err_pulse), 32'd0);

        // Confirm on an empty slot is rejected.
        slot_in = 3'd2;
        set_stock(2, 4'd0);
        ticks(2);
        confirm = 1'b1;
        tick();
        check("t3_err", 32'(err_pulse), 32'd1);
        check("t3_no_req", 32'(buy_req), 32'd0);
        tick();
        check("t3_err_once", 32'(err_pulse), 32'd0);
        confirm = 1'b0;
        tick();

        // Purchase slot 2, browse elsewhere, then pay.
        set_stock(2, 4'd4);
        tick();
        confirm = 1'b1;
        tick();
        check("t4_req", 32'(buy_req), 32'd1);
        check("t4_buy_slot", 32'(buy_slot), 32'd2);
        slot_in = 3'd4;
        ticks(2);
        slot_in = 3'd7;
        ticks(2);
        check("t4_buy_frozen", 32'(buy_slot), 32'd2);
        check("t4_view_frozen", 32'(view_slot), 32'd2);
        pay_done = 1'b1;
        tick();
        pay_done = 1'b0;
        check("t4_vend", 32'(vend_pulse), 32'd1);
        check("t4_req_drop", 32'(buy_req), 32'd0);
        tick();
        check("t4_vend_once", 32'(vend_pulse), 32'd0);

        // Unpaid hold expires after TO cycles.
        slot_in = 3'd2;
        confirm = 1'b0;
        ticks(3);
        confirm = 1'b1;
        tick();
        hold_cycles = (buy_req === 1'b1) ? 1 : 0;
        for (int i = 0; i < 40 && buy_req === 1'b1; i++) begin
            tick();
            if (buy_req === 1'b1) hold_cycles++;
        end
        check("t5_hold_len", 32'(hold_cycles), 32'(TO));
        check("t5_timeout", 32'(timeout), 32'd1);

        // Payment completion outranks cancel.
        confirm = 1'b0;
        ticks(3);
        confirm = 1'b1;
        tick();
        pay_done = 1'b1;
        cancel   = 1'b1;
        tick();
        pay_done = 1'b0;
        cancel   = 1'b0;
        check("t5_done_wins", 32'(vend_pulse), 32'd1);

        // Async reset mid-hold, confirm held through release.
        confirm = 1'b0;
        ticks(3);
        confirm = 1'b1;
        ticks(2);
        check("t6_in_hold", 32'(buy_req), 32'd1);
        @(posedge clk);
        model_step();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("t6_async_req", 32'(buy_req), 32'd0);
        check("t6_no_vend", 32'(vend_pulse), 32'd0);
        compare_all();
        @(negedge clk);
        tick();
        rst = 1'b0;
        ticks(6);
        check("t6_no_retrigger", 32'(buy_req), 32'd0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            browse_en = ($urandom_range(0, 19) != 0);
            slot_in   = LW'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) confirm = ~confirm;
            cancel    = ($urandom_range(0, 29) == 0);
            pay_done  = ($urandom_range(0, 19) == 0);
            pay_abort = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 9) == 0) begin
                for (int k = 0; k < int'(N); k++) set_stock(k, SW'($urandom_range(0, 3)));
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
